// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-detection inputs and pipeline control outputs between datapath and hazard controller
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mc_start;
  logic       mc_done;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_bubble;
  logic [1:0] state;
  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mc_start, mc_done,
    output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, state
  );
  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mc_start, mc_done,
    input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / branch / multi-cycle hazard sequencer; HAZARD_PERF_CNT_EN adds stall and flush counters
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input logic clk,
  input logic reset_n,
  pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);
  typedef enum logic [1:0] {RUN = 2'b00, LSTALL = 2'b01, MC_WAIT = 2'b10} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt, cnt_d;
  logic       load_use;
  assign load_use = hz.ex_mem_read && hz.ex_rd != 5'd0 &&
                    ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
  assign hz.state = state_q;
  // state and remaining load-stall count; only registered state in the controller
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt     <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
    end
  end
  // next state and pipeline controls; reset forces the pipeline frozen and flushed
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt;
    hz.pc_en         = 1'b1;
    hz.if_id_en      = 1'b1;
    hz.id_ex_en      = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_flush   = 1'b0;
    hz.ex_mem_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.ex_branch_taken) begin
          hz.if_id_flush = 1'b1;
          hz.id_ex_flush = 1'b1;
        end else if (hz.mc_start) begin
          if (!hz.mc_done) begin
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.id_ex_en      = 1'b0;
            hz.ex_mem_bubble = 1'b1;
            state_d          = MC_WAIT;
          end
        end else if (load_use) begin
          hz.pc_en       = 1'b0;
          hz.if_id_en    = 1'b0;
          hz.id_ex_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            cnt_d   = 4'(LOAD_STALL_CYCLES - 1);
            state_d = LSTALL;
          end
        end
      end
      LSTALL: begin
        hz.pc_en       = 1'b0;
        hz.if_id_en    = 1'b0;
        hz.id_ex_flush = 1'b1;
        cnt_d          = cnt - 4'd1;
        state_d        = cnt <= 4'd1 ? RUN : LSTALL;
      end
      MC_WAIT: begin
        if (hz.mc_done) begin
          state_d = RUN;
        end else begin
          hz.pc_en         = 1'b0;
          hz.if_id_en      = 1'b0;
          hz.id_ex_en      = 1'b0;
          hz.ex_mem_bubble = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (!reset_n) begin
      hz.pc_en         = 1'b0;
      hz.if_id_en      = 1'b0;
      hz.id_ex_en      = 1'b0;
      hz.if_id_flush   = 1'b1;
      hz.id_ex_flush   = 1'b1;
      hz.ex_mem_bubble = 1'b1;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  // saturating counters; if_id_flush outside reset only rises for an accepted branch flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!hz.pc_en && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (hz.if_id_flush && flush_events != 32'hFFFF_FFFF) flush_events <= flush_events + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench driving a 1-cycle and a 3-cycle load-stall controller side by side
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] stim = 16'h0;
  logic [15:0] sb [$];
  int          checks = 0;
  int          passed = 0;
  // stim = {branch, mc_start, mc_done, mem_read, uses_rs1, uses_rs2, ex_rd, id_rs2}; id_rs1 fixed at 7
  localparam logic [15:0] Z     = 16'h0;
  localparam logic [15:0] LU2   = {6'b000101, 5'd5, 5'd5};
  localparam logic [15:0] LU1   = {6'b000110, 5'd7, 5'd5};
  localparam logic [15:0] LU0   = {6'b000101, 5'd0, 5'd0};
  localparam logic [15:0] NM    = {6'b000111, 5'd9, 5'd5};
  localparam logic [15:0] NOUSE = {6'b000100, 5'd5, 5'd5};
  localparam logic [15:0] BR    = {6'b100000, 10'd0};
  localparam logic [15:0] BRLU  = {6'b100101, 5'd5, 5'd5};
  localparam logic [15:0] BRMS  = {6'b110000, 10'd0};
  localparam logic [15:0] MS    = {6'b010000, 10'd0};
  localparam logic [15:0] MSLU  = {6'b010101, 5'd5, 5'd5};
  localparam logic [15:0] MSD   = {6'b011000, 10'd0};
  localparam logic [15:0] MSDLU = {6'b011101, 5'd5, 5'd5};
  // expected {pc_en,if_id_en,id_ex_en,if_id_flush,id_ex_flush,ex_mem_bubble,state}
  localparam logic [7:0] DEF = 8'hE0, LUS = 8'h28, LST = 8'h29, MCR = 8'h04, MCW = 8'h06;
  localparam logic [7:0] MCD = 8'hE2, BRF = 8'hF8, RST = 8'h1C;

  pipeline_hazard_ctrl_if h1 ();
  pipeline_hazard_ctrl_if h3 ();
  assign {h1.ex_branch_taken, h1.mc_start, h1.mc_done, h1.ex_mem_read, h1.id_uses_rs1, h1.id_uses_rs2, h1.ex_rd, h1.id_rs2} = stim;
  assign {h3.ex_branch_taken, h3.mc_start, h3.mc_done, h3.ex_mem_read, h3.id_uses_rs1, h3.id_uses_rs2, h3.ex_rd, h3.id_rs2} = stim;
  assign h1.id_rs1 = 5'd7;
  assign h3.id_rs1 = 5'd7;
  wire [7:0] o1 = {h1.pc_en, h1.if_id_en, h1.id_ex_en, h1.if_id_flush, h1.id_ex_flush, h1.ex_mem_bubble, h1.state};
  wire [7:0] o3 = {h3.pc_en, h3.if_id_en, h3.id_ex_en, h3.if_id_flush, h3.id_ex_flush, h3.ex_mem_bubble, h3.state};
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fe1, sc3, fe3;
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u1 (.clk(clk), .reset_n(reset_n), .hz(h1), .stall_cycles(sc1), .flush_events(fe1));
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u3 (.clk(clk), .reset_n(reset_n), .hz(h3), .stall_cycles(sc3), .flush_events(fe3));
`else
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u1 (.clk(clk), .reset_n(reset_n), .hz(h1));
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u3 (.clk(clk), .reset_n(reset_n), .hz(h3));
`endif

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [15:0] exp;
    sb.push_back({RST, RST});
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (o1 !== exp[15:8]) $display("FAIL reset_lsc1 got %h want %h", o1, exp[15:8]); else passed++;
    checks++; if (o3 !== exp[7:0]) $display("FAIL reset_lsc3 got %h want %h", o3, exp[7:0]); else passed++;
    #2 reset_n = 1'b1;
    sb.push_back({DEF, DEF});
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (o1 !== exp[15:8]) $display("FAIL reset_release_lsc1 got %h want %h", o1, exp[15:8]); else passed++;
    checks++; if (o3 !== exp[7:0]) $display("FAIL reset_release_lsc3 got %h want %h", o3, exp[7:0]); else passed++;
  endtask

  task automatic test_load_use();
    logic [15:0] s [11];
    logic [7:0]  e1 [11];
    logic [7:0]  e3 [11];
    logic [15:0] exp;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] b1 = sc1, b3 = sc3;
`endif
    s  = '{LU2, BR,  Z,   Z,   LU1, Z,   Z,   Z,   LU0, NM,  NOUSE};
    e1 = '{LUS, BRF, DEF, DEF, LUS, DEF, DEF, DEF, DEF, DEF, DEF};
    e3 = '{LUS, LST, LST, DEF, LUS, LST, LST, DEF, DEF, DEF, DEF};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      stim = s[i];
      sb.push_back({e1[i], e3[i]});
      @(negedge clk);
      exp = sb.pop_front();
      checks++; if (o1 !== exp[15:8]) $display("FAIL load_use_lsc1[%0d] got %h want %h", i, o1, exp[15:8]); else passed++;
      checks++; if (o3 !== exp[7:0]) $display("FAIL load_use_lsc3[%0d] got %h want %h", i, o3, exp[7:0]); else passed++;
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (sc1 !== b1 + 32'd2) $display("FAIL stall_cycles_lsc1 got %0d want %0d", sc1, b1 + 32'd2); else passed++;
    checks++; if (sc3 !== b3 + 32'd6) $display("FAIL stall_cycles_lsc3 got %0d want %0d", sc3, b3 + 32'd6); else passed++;
`endif
  endtask

  task automatic test_multicycle();
    logic [15:0] s [9];
    logic [7:0]  e [9];
    logic [15:0] exp;
    s = '{MS,  MS,  MSLU, BRMS, MSD, Z,   MSD, MSDLU, Z};
    e = '{MCR, MCW, MCW,  MCW,  MCD, DEF, DEF, DEF,   DEF};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      stim = s[i];
      sb.push_back({e[i], e[i]});
      @(negedge clk);
      exp = sb.pop_front();
      checks++; if (o1 !== exp[15:8]) $display("FAIL multicycle_lsc1[%0d] got %h want %h", i, o1, exp[15:8]); else passed++;
      checks++; if (o3 !== exp[7:0]) $display("FAIL multicycle_lsc3[%0d] got %h want %h", i, o3, exp[7:0]); else passed++;
    end
  endtask

  task automatic test_branch();
    logic [15:0] s [4];
    logic [7:0]  e [4];
    logic [15:0] exp;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] b1 = fe1, b3 = fe3;
`endif
    s = '{BRLU, Z,   BRMS, Z};
    e = '{BRF,  DEF, BRF,  DEF};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      stim = s[i];
      sb.push_back({e[i], e[i]});
      @(negedge clk);
      exp = sb.pop_front();
      checks++; if (o1 !== exp[15:8]) $display("FAIL branch_lsc1[%0d] got %h want %h", i, o1, exp[15:8]); else passed++;
      checks++; if (o3 !== exp[7:0]) $display("FAIL branch_lsc3[%0d] got %h want %h", i, o3, exp[7:0]); else passed++;
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (fe1 !== b1 + 32'd2) $display("FAIL flush_events_lsc1 got %0d want %0d", fe1, b1 + 32'd2); else passed++;
    checks++; if (fe3 !== b3 + 32'd2) $display("FAIL flush_events_lsc3 got %0d want %0d", fe3, b3 + 32'd2); else passed++;
`endif
  endtask

  task automatic test_reset_mid_stall();
    logic [15:0] exp;
    @(posedge clk); #1;
    stim = MS;
    sb.push_back({MCR, MCR});
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (o1 !== exp[15:8]) $display("FAIL mid_enter_lsc1 got %h want %h", o1, exp[15:8]); else passed++;
    @(posedge clk); #1;
    sb.push_back({MCW, MCW});
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (o3 !== exp[7:0]) $display("FAIL mid_wait_lsc3 got %h want %h", o3, exp[7:0]); else passed++;
    #1 reset_n = 1'b0;
    sb.push_back({RST, RST});
    #1;
    exp = sb.pop_front();
    checks++; if (o1 !== exp[15:8]) $display("FAIL mid_async_lsc1 got %h want %h", o1, exp[15:8]); else passed++;
    checks++; if (o3 !== exp[7:0]) $display("FAIL mid_async_lsc3 got %h want %h", o3, exp[7:0]); else passed++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    stim = Z;
    sb.push_back({DEF, DEF});
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (o1 !== exp[15:8]) $display("FAIL mid_release_lsc1 got %h want %h", o1, exp[15:8]); else passed++;
    checks++; if (o3 !== exp[7:0]) $display("FAIL mid_release_lsc3 got %h want %h", o3, exp[7:0]); else passed++;
`ifdef HAZARD_PERF_CNT_EN
    checks++; if ({sc1, fe1, sc3, fe3} !== 128'd0) $display("FAIL perf_after_reset got %0d %0d %0d %0d want 0", sc1, fe1, sc3, fe3); else passed++;
`endif
    @(posedge clk); #1;
    sb.push_back({DEF, DEF});
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (o1 !== exp[15:8]) $display("FAIL mid_no_residual_lsc1 got %h want %h", o1, exp[15:8]); else passed++;
    checks++; if (o3 !== exp[7:0]) $display("FAIL mid_no_residual_lsc3 got %h want %h", o3, exp[7:0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
